// File: rtl/int2flt_seq.sv
// Sequential 16-bit two's-complement integer to IEEE-754 half-precision converter.
// Optional single-cycle normalizer enabled by defining INT2FLT_FAST_NORM_EN.
module int2flt_seq #(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       ack,
    output logic       busy,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [3:0] {
        IDLE,
        RD_HI,
        RD_LO,
        PREP,
        NORM,
        ROUND,
        WR_HI,
        WR_LO,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic   req_q;

    logic [7:0]         hi_byte, lo_byte;
    logic               sign;
    logic [15:0]        mag;
    logic [4:0]         expo;
    logic [15:0]        result;
    logic signed [15:0] operand;
    logic [15:0]        abs_val;

    // Round-to-nearest-even on the normalized magnitude; a fraction carry-out
    // leaves the fraction at zero and bumps the exponent.
    function automatic logic [15:0] round_pack(input logic s, input logic [4:0] e,
                                               input logic [15:0] m);
        logic        inc;
        logic [10:0] frac_sum;
        logic [4:0]  e_adj;
        inc      = m[4] & ((|m[3:0]) | m[5]);
        frac_sum = {1'b0, m[14:5]} + {10'd0, inc};
        e_adj    = e + {4'd0, frac_sum[10]};
        return {s, e_adj, frac_sum[9:0]};
    endfunction

`ifdef INT2FLT_FAST_NORM_EN
    function automatic logic [3:0] lead_zeros(input logic [15:0] m);
        logic [3:0] lz;
        lz = 4'd15;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) lz = 4'(15 - i);
        end
        return lz;
    endfunction

    logic [3:0] norm_lz;
    assign norm_lz = lead_zeros(mag);
`endif

    assign operand = signed'({hi_byte, lo_byte});
    // Negating 0x8000 wraps back to 0x8000, which read unsigned is 32768.
    assign abs_val = operand[15] ? $unsigned(-operand) : $unsigned(operand);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req_q <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= req;
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            RD_HI: hi_byte <= mem_rd_data;
            RD_LO: lo_byte <= mem_rd_data;
            PREP: begin
                sign   <= operand[15];
                mag    <= abs_val;
                expo   <= 5'd30;
                result <= 16'h0000;
            end
            NORM: begin
`ifdef INT2FLT_FAST_NORM_EN
                mag  <= mag << norm_lz;
                expo <= 5'd30 - {1'b0, norm_lz};
`else
                mag  <= mag << 1;
                expo <= expo - 5'd1;
`endif
            end
            ROUND: result <= round_pack(sign, expo, mag);
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        ack         = 1'b0;
        busy        = (state != IDLE);
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (state)
            IDLE:  if (req_q && !req) state_nxt = RD_HI;
            RD_HI: begin
                mem_addr  = SRC_ADDR;
                state_nxt = RD_LO;
            end
            RD_LO: begin
                mem_addr  = SRC_ADDR + 8'd1;
                state_nxt = PREP;
            end
            PREP: begin
                if (abs_val == 16'd0) state_nxt = WR_HI;
`ifdef INT2FLT_FAST_NORM_EN
                else                  state_nxt = NORM;
`else
                else if (abs_val[15]) state_nxt = ROUND;
                else                  state_nxt = NORM;
`endif
            end
            NORM: begin
`ifdef INT2FLT_FAST_NORM_EN
                state_nxt = ROUND;
`else
                // The bit about to shift into position 15 ends the loop.
                if (mag[14]) state_nxt = ROUND;
`endif
            end
            ROUND: state_nxt = WR_HI;
            WR_HI: begin
                mem_addr    = DST_ADDR;
                mem_wr_data = result[15:8];
                mem_wr_en   = 1'b1;
                state_nxt   = WR_LO;
            end
            WR_LO: begin
                mem_addr    = DST_ADDR + 8'd1;
                mem_wr_data = result[7:0];
                mem_wr_en   = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int2flt_seq.sv
// Scoreboard bench for int2flt_seq: directed and random operands, latency,
// write-strobe count, ignored restart and mid-conversion reset.
module tb_int2flt_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       ack;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int ack_count = 0;

    logic [15:0] exp_q[$];
    int          lat_q[$];

    int2flt_seq #(.SRC_ADDR(8'd0), .DST_ADDR(8'd2)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .ack(ack),
        .busy(busy),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en)  mem[mem_addr] <= mem_wr_data;
        else if (tb_we) mem[tb_addr]  <= tb_data;
    end

    always @(negedge clk) begin
        if (mem_wr_en) wr_count++;
        if (ack)       ack_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Independent reference: round the magnitude to 11 significant bits.
    function automatic logic [15:0] ref_half(input logic [15:0] x);
        int v, m, p, e, q, sh, rem, half;
        logic s;
        v = int'($signed(x));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 16'h0000;
        p = 15;
        while (((m >> p) & 1) == 0) p--;
        e = 15 + p;
        if (p <= 10) begin
            q = m << (10 - p);
        end else begin
            sh   = p - 10;
            q    = m >> sh;
            rem  = m & ((1 << sh) - 1);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q & 1) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end
        return {s, e[4:0], q[9:0]};
    endfunction

    function automatic int ref_latency(input logic [15:0] x);
        int v, m, p;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        if (m == 0) return 5;
`ifdef INT2FLT_FAST_NORM_EN
        return 7;
`else
        p = 15;
        while (((m >> p) & 1) == 0) p--;
        return 6 + (15 - p);
`endif
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic load(input logic [15:0] x);
        poke(8'd0, x[15:8]);
        poke(8'd1, x[7:0]);
        poke(8'd2, 8'hAA);
        poke(8'd3, 8'hAA);
        wr_count = 0;
    endtask

    // Falling edge of req; the following negedge lies in cycle 0.
    task automatic start_req();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int n0);
        int n;
        bit got;
        logic [15:0] exp_res;
        int exp_lat;
        n   = n0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            if (ack) got = 1'b1;
            else     n++;
        end
        exp_res = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        if (!got) begin
            check_eq({tag, " ack timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, " result"}, {16'd0, mem[2], mem[3]}, {16'd0, exp_res});
        check_eq({tag, " latency"}, n, exp_lat);
        check_eq({tag, " writes"}, wr_count, 2);
        @(negedge clk);
        check_eq({tag, " ack pulse"}, {30'd0, ack, busy}, 32'd0);
    endtask

    task automatic run_conv(input string tag, input logic [15:0] x, input logic [15:0] expected);
        load(x);
        exp_q.push_back(expected);
        lat_q.push_back(ref_latency(x));
        start_req();
        wait_ack(tag, 0);
    endtask

    logic [15:0] rx;
    int          acks_before;

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        tb_we = 1'b0;
        tb_addr = 8'd0;
        tb_data = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset ack", {31'd0, ack}, 32'd0);
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        check_eq("reset wr_en", {31'd0, mem_wr_en}, 32'd0);
        check_eq("reset addr", {24'd0, mem_addr}, 32'd0);
        check_eq("reset wdata", {24'd0, mem_wr_data}, 32'd0);
        reset = 1'b0;

        run_conv("one",    16'h0001, 16'h3C00);
        run_conv("neg1",   16'hFFFF, 16'hBC00);
        run_conv("min",    16'h8000, 16'hF800);
        run_conv("zero",   16'h0000, 16'h0000);
        run_conv("max",    16'h7FFF, 16'h7800);
        run_conv("tie_ev", 16'h0801, 16'h6800);
        run_conv("tie_od", 16'h0803, 16'h6802);
        run_conv("4095",   16'h0FFF, 16'h6C00);

        // Second falling edge lands in cycle 3 (NORM) and must be ignored.
        load(16'h0001);
        exp_q.push_back(16'h3C00);
        lat_q.push_back(ref_latency(16'h0001));
        acks_before = ack_count;
        start_req();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_ack("restart", 4);
        repeat (3) @(negedge clk);
        check_eq("restart idle", {31'd0, busy}, 32'd0);
        check_eq("restart acks", ack_count - acks_before, 1);
        run_conv("after", 16'hFFF0, 16'hCC00);

        // Reset asserted while in NORM aborts the conversion.
        load(16'h0001);
        acks_before = ack_count;
        start_req();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort busy", {31'd0, busy}, 32'd0);
        check_eq("abort ack", {31'd0, ack}, 32'd0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check_eq("abort acks", ack_count - acks_before, 0);
        check_eq("abort writes", wr_count, 0);
        check_eq("abort mem", {16'd0, mem[2], mem[3]}, 32'h0000AAAA);
        run_conv("100", 16'h0064, 16'h5640);

        for (int i = 0; i < 12; i++) begin
            rx = 16'($urandom_range(0, 65535));
            run_conv($sformatf("rand%0d_%04h", i, rx), rx, ref_half(rx));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
